narnet_engine_p: RTL and testbench

- Parametrised, time-multiplexed NAR network inference engine.
- Per sample: y = b2 + sum_h W2[h]*tanh(b1[h] + sum_t W1[h][t]*x[n-t]).
- Sits between the sample source and the prediction consumer.
- Generalises the fixed 16-tap/5-neuron engine:
  - TAPS, HIDDEN and fixed-point format are parameters.
  - Weights are loaded at run time into an internal RAM.
  - Both ports use valid/ready handshakes.
  - Adds a closed-loop (free-running prediction) mode.

---
 rtl/narnet_engine_p.sv | 225 ++++++++++++++++++++++
 tb/tb_narnet_engine_p.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/narnet_engine_p.sv
// NAR network inference engine: one shared MAC walks HIDDEN x TAPS products, then HIDDEN
// output products. Weights live in a run-time loaded RAM. Both sample ports are valid/ready.

module tanh_lut #(
  parameter int N = 10,
  parameter int Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x_i,
  output logic [N-1:0] y_o
);
  // Odd-symmetric piecewise-linear tanh: slope 1 below 0.5, slope 1/2 up to 1.5, then 1.0.
  localparam logic [N:0] HALF = (N+1)'(1 << (Q-1));
  localparam logic [N:0] THR  = (N+1)'(3 << (Q-1));
  localparam logic [N:0] QTR  = (N+1)'(1 << (Q-2));
  localparam logic [N:0] ONE  = (N+1)'(1 << Q);

  logic [N:0]   mag_d, m_d;
  logic [N-1:0] y_q;

  always_comb begin
    mag_d = x_i[N-1] ? ({1'b0, ~x_i} + 1'b1) : {1'b0, x_i};
    if (mag_d < HALF)     m_d = mag_d;
    else if (mag_d < THR) m_d = (mag_d >> 1) + QTR;
    else                  m_d = ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y_q <= '0;
    else      y_q <= x_i[N-1] ? N'(-m_d) : N'(m_d);
  end

  assign y_o = y_q;
endmodule

module narnet_engine_p #(
  parameter int N      = 10,
  parameter int Q      = 8,
  parameter int TAPS   = 16,
  parameter int HIDDEN = 5,
  parameter int INIT   = 96,
  parameter int WDEPTH = HIDDEN*(TAPS+2)+1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [N-1:0]       x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic signed [N-1:0]       y_out,
  output logic                      y_valid,
  input  logic                      y_ready,
  input  logic                      closed_loop,
  input  logic                      flush,
  input  logic                      w_we,
  input  logic [$clog2(WDEPTH)-1:0] w_addr,
  input  logic signed [N-1:0]       w_data,
  output logic                      busy,
  output logic                      err
);
  localparam int AW   = $clog2(WDEPTH);
  localparam int MAXT = (TAPS > HIDDEN) ? TAPS : HIDDEN;
  localparam int ACCW = 2*N + $clog2(MAXT+1);
  localparam int CW   = $clog2(MAXT+2);
  localparam int HW   = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
  localparam int PW   = $clog2(TAPS);
  localparam int B2A  = HIDDEN*(TAPS+1);
  localparam logic [CW-1:0]        TAPS_C = CW'(TAPS);
  localparam logic signed [N-1:0]  INIT_V = N'(INIT);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'((2**(N-1))-1);
  localparam logic signed [ACCW-1:0] SMIN = ACCW'(-(2**(N-1)));

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_L1, S_L2, S_OUT} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [HW-1:0]          h_q;
  logic [PW-1:0]          wp_q;
  logic signed [N-1:0]    taps_q [TAPS];
  logic signed [N-1:0]    hid_q  [HIDDEN];
  logic signed [N-1:0]    sample_q, y_out_q;
  logic                   y_valid_q, err_q, run_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [N-1:0]    ram_q [WDEPTH];
  logic signed [N-1:0]    rd_q;

  logic [AW-1:0]          ra_d;
  logic                   idle, last_h, w_en, do_flush, acc_open, acc_loop;
  int                     ti;
  logic signed [N-1:0]    op_b, sat_acc, tanh_y;
  logic signed [2*N-1:0]  prod;
  logic signed [ACCW-1:0] acc_sum, bias_acc;

  function automatic logic signed [N-1:0] sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> Q;
    if (s > SMAX)      sat = N'(SMAX);
    else if (s < SMIN) sat = N'(SMIN);
    else               sat = N'(s);
  endfunction

  assign idle     = (state_q == S_IDLE);
  assign last_h   = (h_q == HW'(HIDDEN-1));
  assign x_ready  = idle & run_q & ~y_valid_q & ~closed_loop;
  assign do_flush = idle & flush;
  assign acc_open = x_ready & x_valid & ~flush;
  assign acc_loop = idle & run_q & ~y_valid_q & closed_loop & ~flush;
  assign w_en     = idle & w_we & (int'(w_addr) < WDEPTH);

  // Address of the word the MAC needs next cycle, so RAM read latency is hidden.
  always_comb begin
    ra_d = '0;
    case (state_q)
      S_IDLE: ra_d = '0;
      S_PUSH: ra_d = AW'(HIDDEN);
      S_L1: begin
        if (int'(cnt_q) < TAPS-1)
          ra_d = AW'(HIDDEN + int'(h_q)*TAPS + int'(cnt_q) + 1);
        else if (cnt_q == TAPS_C)
          ra_d = last_h ? AW'(B2A) : AW'(int'(h_q) + 1);
        else if (int'(cnt_q) == TAPS+1)
          ra_d = last_h ? AW'(B2A+1) : AW'(HIDDEN + (int'(h_q)+1)*TAPS);
      end
      S_L2: if (int'(cnt_q) < HIDDEN-1) ra_d = AW'(B2A + 2 + int'(cnt_q));
      default: ra_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_en) ram_q[w_addr] <= w_data;
    rd_q <= ram_q[ra_d];
  end

  // Tap t is the sample pushed t accepts ago; wp_q already points past the newest.
  always_comb begin
    ti = int'(wp_q) + TAPS - 1 - int'(cnt_q);
    if (ti >= TAPS) ti = ti - TAPS;
    if (ti < 0)     ti = 0;
    op_b = (state_q == S_L2) ? hid_q[HW'(cnt_q)] : taps_q[PW'(ti)];
  end

  assign prod     = (2*N)'(rd_q) * (2*N)'(op_b);
  assign acc_sum  = acc_q + ACCW'(prod);
  assign bias_acc = ACCW'(rd_q) <<< Q;
  assign sat_acc  = sat(acc_q);

  tanh_lut #(.N(N), .Q(Q)) u_tanh (
    .clk (clk),
    .rst (rst),
    .x_i (sat_acc),
    .y_o (tanh_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      h_q       <= '0;
      wp_q      <= '0;
      for (int i = 0; i < TAPS; i++)   taps_q[i] <= INIT_V;
      for (int i = 0; i < HIDDEN; i++) hid_q[i]  <= '0;
      sample_q  <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      run_q <= 1'b1;
      if (!idle && (w_we || flush)) err_q <= 1'b1;
      if (y_valid_q && y_ready) y_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (do_flush) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= INIT_V;
          end else if (acc_open) begin
            sample_q <= x_in;
            state_q  <= S_PUSH;
          end else if (acc_loop) begin
            sample_q <= y_out_q;
            state_q  <= S_PUSH;
          end
        end
        S_PUSH: begin
          taps_q[wp_q] <= sample_q;
          wp_q    <= (int'(wp_q) == TAPS-1) ? '0 : wp_q + 1'b1;
          acc_q   <= bias_acc;
          cnt_q   <= '0;
          h_q     <= '0;
          state_q <= S_L1;
        end
        S_L1: begin
          if (cnt_q < TAPS_C) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 1'b1;
          end else if (cnt_q == TAPS_C) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            hid_q[h_q] <= tanh_y;
            cnt_q      <= '0;
            acc_q      <= bias_acc;
            if (last_h) state_q <= S_L2;
            else        h_q     <= h_q + 1'b1;
          end
        end
        S_L2: begin
          acc_q <= acc_sum;
          if (int'(cnt_q) == HIDDEN-1) state_q <= S_OUT;
          else                         cnt_q   <= cnt_q + 1'b1;
        end
        S_OUT: begin
          y_out_q   <= sat_acc;
          y_valid_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = ~idle;
  assign err     = err_q;
endmodule

// File: tb/tb_narnet_engine_p.sv
// Directed-plus-random bench for narnet_engine_p against an integer model of the network equation.
module tb_narnet_engine_p;
  localparam int N = 10, Q = 8, TAPS = 16, HID = 5, INIT = 96;
  localparam int WDEPTH = HID*(TAPS+2)+1;
  localparam int AW = $clog2(WDEPTH);
  localparam int LAT = 2 + HID*(TAPS+3);
  localparam int B2A = HID*(TAPS+1);

  logic clk = 1'b0;
  logic rst, x_valid, x_ready, y_valid, y_ready, closed_loop, flush, w_we, busy, err;
  logic [N-1:0] x_in, y_out, w_data;
  logic [AW-1:0] w_addr;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  int m_b1 [HID];
  int m_w1 [HID][TAPS];
  int m_b2;
  int m_w2 [HID];
  int hist [$];
  int last_y;

  narnet_engine_p #(.N(N), .Q(Q), .TAPS(TAPS), .HIDDEN(HID), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .closed_loop(closed_loop),
    .flush(flush), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input int exp);
    chk(tag, {22'd0, y_out}, {22'd0, 10'(exp)});
  endtask

  function automatic int s10(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat_n(input longint v);
    if (v > 511)  return 511;
    if (v < -512) return -512;
    return int'(v);
  endfunction

  function automatic int tanh_m(input int v);
    int a, m;
    a = (v < 0) ? -v : v;
    if (a < 128)      m = a;
    else if (a < 384) m = a / 2 + 64;
    else              m = 256;
    return (v < 0) ? -m : m;
  endfunction

  // y = sat(floor((b2 + sum W2*tanh(sat(floor(b1 + sum W1*x)))) )) in Q8 raw integers.
  function automatic int compute();
    longint s;
    int hv [HID];
    for (int h = 0; h < HID; h++) begin
      s = longint'(m_b1[h]) * 256;
      for (int t = 0; t < TAPS; t++) s += longint'(m_w1[h][t]) * hist[t];
      hv[h] = tanh_m(sat_n(s >>> 8));
    end
    s = longint'(m_b2) * 256;
    for (int h = 0; h < HID; h++) s += longint'(m_w2[h]) * hv[h];
    return sat_n(s >>> 8);
  endfunction

  task automatic reset_hist();
    hist.delete();
    for (int i = 0; i < TAPS; i++) hist.push_back(INIT);
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    w_we = 1'b1; w_addr = AW'(addr); w_data = 10'(data);
    @(posedge clk); #1 w_we = 1'b0;
  endtask

  task automatic load_model();
    for (int h = 0; h < HID; h++) wr(h, m_b1[h]);
    for (int h = 0; h < HID; h++)
      for (int t = 0; t < TAPS; t++) wr(HID + h*TAPS + t, m_w1[h][t]);
    wr(B2A, m_b2);
    for (int h = 0; h < HID; h++) wr(B2A + 1 + h, m_w2[h]);
  endtask

  task automatic set_weights(input int amp, input int w1v, input int w2v, input int b2v);
    for (int h = 0; h < HID; h++) begin
      m_b1[h] = (amp > 0) ? int'($urandom_range(0, 2*amp)) - amp : 0;
      for (int t = 0; t < TAPS; t++)
        m_w1[h][t] = (amp > 0) ? int'($urandom_range(0, 2*amp)) - amp : 0;
      m_w2[h] = (amp > 0) ? int'($urandom_range(0, 2*amp)) - amp : 0;
    end
    if (amp == 0) begin
      for (int h = 0; h < HID; h++) begin
        m_w1[h][0] = w1v;
        m_w2[h] = w2v;
      end
      m_b2 = b2v;
    end else begin
      m_b2 = int'($urandom_range(0, 2*amp)) - amp;
    end
  endtask

  task automatic start_sample(input int x);
    int n = 0;
    @(negedge clk);
    while (!x_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept_wait", {31'd0, x_ready}, 32'd1);
    x_in = 10'(x); x_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc; x_valid = 1'b0;
    hist.push_front(s10(10'(x)));
    void'(hist.pop_back());
  endtask

  task automatic finish_sample(input int hold, input bit chk_lat, input int exp);
    int n = 0;
    bit xr_bad = 1'b0, stable = 1'b1;
    logic [9:0] yd;
    while (!y_valid && n < 400) begin
      @(posedge clk); #1; n++;
      if (x_ready) xr_bad = 1'b1;
    end
    chk("y_valid_timeout", {31'd0, y_valid}, 32'd1);
    if (chk_lat) chk("latency", cyc - acc_cyc, LAT);
    chk("x_ready_while_busy", {31'd0, xr_bad}, 32'd0);
    chk_y("y_out", exp);
    last_y = exp;
    if (hold > 0) begin
      yd = y_out; x_valid = 1'b1; x_in = 10'($urandom_range(0, 1023));
      repeat (hold) begin
        @(posedge clk); #1;
        if (!y_valid || y_out !== yd || x_ready || busy) stable = 1'b0;
      end
      x_valid = 1'b0;
      chk("hold_stable", {31'd0, stable}, 32'd1);
    end
    y_ready = 1'b1;
    @(posedge clk); #1 y_ready = 1'b0;
    chk("y_valid_drop", {31'd0, y_valid}, 32'd0);
    chk_y("y_out_hold_after", exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_y_out"}, {22'd0, y_out}, 32'd0);
    chk({tag, "_y_valid"}, {31'd0, y_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_x_ready"}, {31'd0, x_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; x_valid = 1'b0; y_ready = 1'b0; closed_loop = 1'b0; flush = 1'b0;
    w_we = 1'b0; x_in = '0; w_addr = '0; w_data = '0;
    reset_hist(); last_y = 0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Zero weights, b2 = 0.25: output is the bias alone.
    set_weights(0, 0, 0, 64);
    for (int h = 0; h < HID; h++) m_b1[h] = int'($urandom_range(0, 200)) - 100;
    load_model();
    start_sample(int'($urandom_range(0, 1023)));
    finish_sample(0, 1'b1, 'h040);

    // Identity-like path: y = tanh(x) through neuron 0 only.
    set_weights(0, 256, 0, 0);
    for (int h = 1; h < HID; h++) m_w1[h][0] = 0;
    m_w2[0] = 256;
    load_model();
    begin
      int xs [5];
      xs = '{'h100, 'h080, 'h300, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))};
      for (int i = 0; i < 5; i++) begin
        start_sample(xs[i]);
        finish_sample(0, 1'b1, compute());
      end
    end

    // Saturation at both rails.
    set_weights(0, 511, 511, 0);
    load_model();
    start_sample('h100);
    finish_sample(0, 1'b1, 'h1FF);
    start_sample('h300);
    finish_sample(0, 1'b1, -512);

    // Consumer backpressure for 20 cycles.
    set_weights(40, 0, 0, 0);
    load_model();
    start_sample(int'($urandom_range(0, 1023)));
    finish_sample(20, 1'b1, compute());

    // Writes and flush while busy are dropped and set err.
    start_sample(int'($urandom_range(0, 1023)));
    repeat (10) @(posedge clk);
    #1 w_we = 1'b1; w_addr = AW'(B2A); w_data = 10'h0AA;
    @(posedge clk); #1 w_we = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    finish_sample(0, 1'b1, compute());
    chk("err_after_busy_write", {31'd0, err}, 32'd1);
    start_sample(int'($urandom_range(0, 1023)));
    finish_sample(0, 1'b1, compute());

    // Out-of-range address is ignored; IDLE flush reloads INIT.
    wr(100, 'h155);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    reset_hist();
    start_sample(int'($urandom_range(0, 1023)));
    finish_sample(0, 1'b1, compute());
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Closed loop: three predictions fed back; dropping the mode mid-run stops after the third.
    @(negedge clk); closed_loop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hist.push_front(last_y);
      void'(hist.pop_back());
      if (k == 2) begin
        repeat (5) @(posedge clk);
        #1 closed_loop = 1'b0;
      end
      finish_sample(0, 1'b0, compute());
    end
    repeat (5) @(posedge clk);
    #1 chk("closed_loop_stopped", {31'd0, busy}, 32'd0);

    // Reset 40 cycles into a computation.
    start_sample(int'($urandom_range(0, 1023)));
    repeat (39) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    reset_hist(); last_y = 0;
    @(negedge clk); rst = 1'b1;
    start_sample(int'($urandom_range(0, 1023)));
    finish_sample(0, 1'b1, compute());

    // Random weight sets and samples.
    for (int r = 0; r < 2; r++) begin
      set_weights(48, 0, 0, 0);
      load_model();
      for (int i = 0; i < 3; i++) begin
        start_sample(int'($urandom_range(0, 1023)));
        finish_sample(0, 1'b1, compute());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
